// File: rtl/ws2812b_frame_limiter.sv
// Rate limiter in front of the WS2812B strip controller: commits LED patterns no
// more often than once per hold-off window and keeps only the latest deferred write.
module ws2812b_frame_limiter #(
  parameter int N              = 32,
  parameter int HOLDOFF_CYCLES = 60000,
  parameter int CNT_W          = 16
) (
  input  logic         clk_50,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [N-1:0] wr_data,
  output logic [N-1:0] led_data,
  output logic         update_pulse,
  output logic         busy,
  output logic         pending,
  output logic [7:0]   drop_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic [N-1:0]     pend_reg, pend_nxt;
  logic [N-1:0]     led_nxt;
  logic [N-1:0]     cand;
  logic             cand_valid;
  logic             pending_nxt;
  logic             pulse_nxt;
  logic             drop_inc;

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    pend_nxt    = pend_reg;
    pending_nxt = pending;
    led_nxt     = led_data;
    pulse_nxt   = 1'b0;
    drop_inc    = 1'b0;
    cand        = pend_reg;
    cand_valid  = 1'b0;

    case (state)
      IDLE: begin
        counter_nxt = '0;
        pending_nxt = 1'b0;
        if (wr_en && (wr_data != led_data)) begin
          led_nxt     = wr_data;
          pulse_nxt   = 1'b1;
          counter_nxt = RELOAD;
          state_nxt   = HOLD;
        end
      end

      HOLD: begin
        if (counter != '0) begin
          counter_nxt = counter - 1'b1;
          if (wr_en) begin
            pend_nxt    = wr_data;
            pending_nxt = 1'b1;
            drop_inc    = pending && (wr_data != pend_reg);
          end
        end else begin
          // Expiry: a write in this very cycle beats the stored one.
          drop_inc = wr_en && pending && (wr_data != pend_reg);
          if (wr_en) begin
            cand       = wr_data;
            cand_valid = 1'b1;
          end else if (pending) begin
            cand       = pend_reg;
            cand_valid = 1'b1;
          end
          pending_nxt = 1'b0;
          if (cand_valid && (cand != led_data)) begin
            led_nxt     = cand;
            pulse_nxt   = 1'b1;
            counter_nxt = RELOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt   = IDLE;
        counter_nxt = '0;
        pending_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      led_data     <= '0;
      pend_reg     <= '0;
      pending      <= 1'b0;
      update_pulse <= 1'b0;
      busy         <= 1'b0;
      drop_count   <= '0;
    end else begin
      state        <= state_nxt;
      counter      <= counter_nxt;
      led_data     <= led_nxt;
      pend_reg     <= pend_nxt;
      pending      <= pending_nxt;
      update_pulse <= pulse_nxt;
      busy         <= (state_nxt == HOLD);
      if (drop_inc && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ws2812b_frame_limiter.sv
// Bench for ws2812b_frame_limiter: scoreboarded commits on a short hold-off instance,
// plus a long hold-off instance for drop counter saturation.
module tb_ws2812b_frame_limiter;

  localparam int N    = 32;
  localparam int HO   = 10;
  localparam int HO2  = 400;

  logic         clk_50;
  logic         rst;
  logic         wr_en;
  logic [N-1:0] wr_data;
  logic [N-1:0] led_data;
  logic         update_pulse;
  logic         busy;
  logic         pending;
  logic [7:0]   drop_count;

  logic         wr_en2;
  logic [N-1:0] wr_data2;
  logic [N-1:0] led_data2;
  logic         update_pulse2;
  logic         busy2;
  logic         pending2;
  logic [7:0]   drop_count2;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int last_pulse;
  logic [N-1:0] prev_led;
  logic [N-1:0] exp_q[$];

  ws2812b_frame_limiter #(.N(N), .HOLDOFF_CYCLES(HO), .CNT_W(16)) dut (
    .clk_50(clk_50), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .led_data(led_data), .update_pulse(update_pulse), .busy(busy),
    .pending(pending), .drop_count(drop_count)
  );

  ws2812b_frame_limiter #(.N(N), .HOLDOFF_CYCLES(HO2), .CNT_W(16)) dut2 (
    .clk_50(clk_50), .rst(rst), .wr_en(wr_en2), .wr_data(wr_data2),
    .led_data(led_data2), .update_pulse(update_pulse2), .busy(busy2),
    .pending(pending2), .drop_count(drop_count2)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) cyc_n++;

  // Commit monitor: every pulse pops the scoreboard; led_data may only move on a pulse.
  always @(negedge clk_50) begin
    if (rst) begin
      last_pulse = -1000;
      prev_led   = led_data;
    end else begin
      if (update_pulse) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_commit: got %h, expected no commit", led_data);
        end else begin
          logic [N-1:0] e;
          e = exp_q.pop_front();
          if (led_data !== e) begin
            errors++;
            $display("FAIL sb_commit: got %h, expected %h", led_data, e);
          end
        end
        checks++;
        if (cyc_n - last_pulse < HO) begin
          errors++;
          $display("FAIL commit_gap: got %0d cycles, expected >= %0d", cyc_n - last_pulse, HO);
        end
        last_pulse = cyc_n;
      end else if (led_data !== prev_led) begin
        checks++;
        errors++;
        $display("FAIL led_stable: got %h, expected %h (no pulse)", led_data, prev_led);
      end
      prev_led = led_data;
    end
  end

  task automatic cyc();
    @(posedge clk_50);
    #1;
  endtask

  task automatic write(input logic [N-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (led_data !== '0)       begin errors++; $display("FAIL rst_init_led: got %h, expected 0", led_data); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_init_busy: got %b, expected 0", busy); end
    checks++; if (update_pulse !== 1'b0) begin errors++; $display("FAIL rst_init_pulse: got %b, expected 0", update_pulse); end
    checks++; if (drop_count !== 8'd0)   begin errors++; $display("FAIL rst_init_drop: got %0d, expected 0", drop_count); end
    exp_q.push_back(32'hA);
    write(32'hA);
    write(32'hB);
    write(32'hC);
    checks++; if (pending !== 1'b1)      begin errors++; $display("FAIL rst_pre_pending: got %b, expected 1", pending); end
    checks++; if (drop_count !== 8'd1)   begin errors++; $display("FAIL rst_pre_drop: got %0d, expected 1", drop_count); end
    #5 rst = 1'b1;
    #1;
    checks++; if (led_data !== '0)       begin errors++; $display("FAIL rst_async_led: got %h, expected 0", led_data); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_async_busy: got %b, expected 0", busy); end
    checks++; if (pending !== 1'b0)      begin errors++; $display("FAIL rst_async_pending: got %b, expected 0", pending); end
    checks++; if (drop_count !== 8'd0)   begin errors++; $display("FAIL rst_async_drop: got %0d, expected 0", drop_count); end
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_single_write();
    exp_q.push_back(32'h0000_00FF);
    write(32'h0000_00FF);
    checks++; if (led_data !== 32'hFF)   begin errors++; $display("FAIL single_led: got %h, expected 000000ff", led_data); end
    checks++; if (update_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse: got %b, expected 1", update_pulse); end
    checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL single_busy0: got %b, expected 1", busy); end
    for (int i = 1; i < HO; i++) begin
      cyc();
      checks++;
      if (busy !== 1'b1 || update_pulse !== 1'b0) begin
        errors++;
        $display("FAIL single_hold: cycle %0d got busy=%b pulse=%b, expected busy=1 pulse=0", i, busy, update_pulse);
      end
    end
    cyc();
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL single_idle: got busy=%b, expected 0", busy); end
  endtask

  task automatic test_redundant_write();
    write(32'hFF);
    checks++; if (update_pulse !== 1'b0) begin errors++; $display("FAIL redundant_pulse: got %b, expected 0", update_pulse); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL redundant_busy: got %b, expected 0", busy); end
    cyc();
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL redundant_busy2: got %b, expected 0", busy); end
  endtask

  task automatic test_coalescing();
    exp_q.push_back(32'h1);
    write(32'h1);
    cyc();
    cyc();
    write(32'h2);
    cyc();
    exp_q.push_back(32'h4);
    write(32'h4);
    for (int i = 0; i < 4; i++) cyc();
    checks++; if (led_data !== 32'h1)    begin errors++; $display("FAIL coal_before: got %h, expected 00000001", led_data); end
    cyc();
    checks++; if (led_data !== 32'h4 || update_pulse !== 1'b1) begin
      errors++; $display("FAIL coal_commit: got led=%h pulse=%b, expected led=00000004 pulse=1", led_data, update_pulse);
    end
    checks++; if (drop_count !== 8'd1)   begin errors++; $display("FAIL coal_drop: got %0d, expected 1", drop_count); end
    for (int i = 1; i < HO; i++) cyc();
    checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL coal_hold2: got busy=%b, expected 1", busy); end
    cyc();
    checks++; if (busy !== 1'b0 || pending !== 1'b0) begin
      errors++; $display("FAIL coal_idle: got busy=%b pending=%b, expected 0 0", busy, pending);
    end
  endtask

  task automatic test_expiry_collision();
    exp_q.push_back(32'h20);
    write(32'h20);
    cyc();
    write(32'h8);
    for (int i = 0; i < 7; i++) cyc();
    exp_q.push_back(32'h10);
    write(32'h10);
    checks++; if (led_data !== 32'h10 || update_pulse !== 1'b1) begin
      errors++; $display("FAIL exp_commit: got led=%h pulse=%b, expected led=00000010 pulse=1", led_data, update_pulse);
    end
    checks++; if (drop_count !== 8'd2)   begin errors++; $display("FAIL exp_drop: got %0d, expected 2", drop_count); end
    checks++; if (pending !== 1'b0)      begin errors++; $display("FAIL exp_pending: got %b, expected 0", pending); end
    for (int i = 0; i < HO; i++) cyc();
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL exp_idle: got busy=%b, expected 0", busy); end
  endtask

  task automatic test_saturation();
    int n;
    bit seen;
    wr_en2   = 1'b1;
    wr_data2 = 32'h1;
    cyc();
    wr_en2   = 1'b0;
    checks++; if (update_pulse2 !== 1'b1 || led_data2 !== 32'h1) begin
      errors++; $display("FAIL sat_first: got led=%h pulse=%b, expected led=00000001 pulse=1", led_data2, update_pulse2);
    end
    for (int i = 0; i < 300; i++) begin
      wr_en2   = 1'b1;
      wr_data2 = 32'h1000 + 32'(i);
      cyc();
    end
    wr_en2 = 1'b0;
    checks++; if (drop_count2 !== 8'd255) begin errors++; $display("FAIL sat_drop: got %0d, expected 255", drop_count2); end
    checks++; if (led_data2 !== 32'h1 || pending2 !== 1'b1) begin
      errors++; $display("FAIL sat_hold: got led=%h pending=%b, expected led=00000001 pending=1", led_data2, pending2);
    end
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 200) begin
      cyc();
      n++;
      if (update_pulse2) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL sat_timeout: got no commit in %0d cycles, expected one", n); end
    checks++; if (led_data2 !== 32'h1000 + 32'd299) begin
      errors++; $display("FAIL sat_commit: got %h, expected %h", led_data2, 32'h1000 + 32'd299);
    end
    checks++; if (drop_count2 !== 8'd255) begin errors++; $display("FAIL sat_stay: got %0d, expected 255", drop_count2); end
  endtask

  initial begin
    wr_en    = 1'b0;
    wr_data  = '0;
    wr_en2   = 1'b0;
    wr_data2 = '0;
    rst      = 1'b0;
    #2 rst   = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    test_reset();
    test_single_write();
    test_redundant_write();
    test_coalescing();
    test_expiry_collision();
    test_saturation();
    cyc();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d outstanding commits, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
